// File: rtl/mul_pkg.sv
// Shared definitions for the iterative radix-4 multiplier.
//   state_t       : controller states (idle, stepping, result pulse)
//   DIGW / SELW   : multiplier digit width and digit-select width
//   DEFAULT_WIDTH : default operand width
package mul_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DIGW          = 2;
    localparam int SELW          = 5;
    localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/mul_pp_sel.sv
// Partial-product selector for one radix-4 step.
// Picks the multiple of the extended multiplicand that one digit contributes.
// Optional feature macro: MUL_SIGNED_EN. With this macro, the most-significant
// digit of a signed multiplier is read as a two's-complement digit. The -2A and -A
// multiples are returned as +2A / +A together with a subtract request.
// Ports:
//   digit     in  2       multiplier digit
//   a_ext     in  WIDTH+2 extended multiplicand A
//   a3_ext    in  WIDTH+2 extended 3A
//   is_last   in  1       digit is the most-significant one (MUL_SIGNED_EN only)
//   is_signed in  1       two's-complement mode (MUL_SIGNED_EN only)
//   multiple  out WIDTH+2 selected magnitude
//   sub       out 1       subtract multiple instead of adding (MUL_SIGNED_EN only)
module mul_pp_sel
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [DIGW-1:0]  digit,
    input  logic [WIDTH+1:0] a_ext,
    input  logic [WIDTH+1:0] a3_ext,
`ifdef MUL_SIGNED_EN
    input  logic             is_last,
    input  logic             is_signed,
    output logic             sub,
`endif
    output logic [WIDTH+1:0] multiple
);

`ifdef MUL_SIGNED_EN
    logic neg_digit_s;
    assign neg_digit_s = is_last & is_signed;
`endif

    // Digit decode: choose 0, A, 2A or 3A.
    // In signed mode, the top digit can instead select -2A or -A.
    always_comb begin
        multiple = {(WIDTH+2){1'b0}};
`ifdef MUL_SIGNED_EN
        sub      = 1'b0;
`endif
        case (digit)
            2'd0: multiple = {(WIDTH+2){1'b0}};
            2'd1: multiple = a_ext;
            2'd2: begin
                multiple = a_ext << 1;
`ifdef MUL_SIGNED_EN
                sub      = neg_digit_s;
`endif
            end
            2'd3: begin
`ifdef MUL_SIGNED_EN
                if (neg_digit_s) begin
                    multiple = a_ext;
                    sub      = 1'b1;
                end else begin
                    multiple = a3_ext;
                    sub      = 1'b0;
                end
`else
                multiple = a3_ext;
`endif
            end
            default: multiple = {(WIDTH+2){1'b0}};
        endcase
    end

endmodule

// File: rtl/mul_radix4_seq.sv
// Iterative radix-4 multiplier.
// The multiplier consumes one 2-bit multiplier digit per cycle from an external
// digit mux and drives that mux through dig_sel. It accumulates the product
// in a (2*WIDTH+2)-bit shift register.
// Optional feature macro: MUL_SIGNED_EN. This macro adds the is_signed port
// and two's-complement multiplication.
// Ports:
//   clk       in  1        rising-edge clock
//   rst_n     in  1        synchronous active-low reset
//   start     in  1        start request, honoured only when idle
//   a         in  WIDTH    multiplicand, latched on accepted start
//   is_signed in  1        two's-complement mode (MUL_SIGNED_EN only)
//   dig_in    in  2        multiplier digit selected by dig_sel
//   dig_sel   out 5        digit index, 0 outside RUN
//   busy      out 1        high while stepping
//   done      out 1        one-cycle result-valid pulse
//   product   out 2*WIDTH  result, held until the next accepted start
module mul_radix4_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
`ifdef MUL_SIGNED_EN
    input  logic               is_signed,
`endif
    input  logic [DIGW-1:0]    dig_in,
    output logic [SELW-1:0]    dig_sel,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int NDIG = WIDTH / 2;
    localparam int EW   = WIDTH + 2;
    localparam int PW   = 2 * WIDTH + 2;
    localparam logic [SELW-1:0] LAST_K = SELW'(NDIG - 1);

    state_t               state_r, state_s;
    logic [EW-1:0]        a_r, a3_r;
    logic [PW-1:0]        p_r, p_next_s;
    logic [SELW-1:0]      k_r;
    logic                 busy_r, done_r;
    logic [2*WIDTH-1:0]   product_r;
    logic [EW-1:0]        a_ext_s, a3_ext_s;
    logic [EW-1:0]        mult_s, hi_sum_s;
    logic                 fill_s;
`ifdef MUL_SIGNED_EN
    logic                 signed_r;
    logic                 sub_s;
    logic                 is_last_s;
    assign is_last_s = (k_r == LAST_K);
`endif

    assign dig_sel = k_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

    // Extend the incoming multiplicand and form 3A for latching on start.
    always_comb begin
        a_ext_s = {2'b00, a};
`ifdef MUL_SIGNED_EN
        if (is_signed) begin
            a_ext_s = {{2{a[WIDTH-1]}}, a};
        end else begin
            a_ext_s = {2'b00, a};
        end
`endif
        a3_ext_s = a_ext_s + (a_ext_s << 1);
    end

    mul_pp_sel #(
        .WIDTH (WIDTH)
    ) u_pp_sel (
        .digit     (dig_in),
        .a_ext     (a_r),
        .a3_ext    (a3_r),
`ifdef MUL_SIGNED_EN
        .is_last   (is_last_s),
        .is_signed (signed_r),
        .sub       (sub_s),
`endif
        .multiple  (mult_s)
    );

    // One accumulation step: add/sub into the upper part, then shift right by two.
    always_comb begin
`ifdef MUL_SIGNED_EN
        if (sub_s) begin
            hi_sum_s = p_r[PW-1 -: EW] - mult_s;
        end else begin
            hi_sum_s = p_r[PW-1 -: EW] + mult_s;
        end
        fill_s = signed_r & hi_sum_s[EW-1];
`else
        hi_sum_s = p_r[PW-1 -: EW] + mult_s;
        fill_s   = 1'b0;
`endif
        p_next_s = {{2{fill_s}}, hi_sum_s, p_r[WIDTH-1:2]};
    end

    // Next-state logic for IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_RUN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (k_r == LAST_K) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State, operand, accumulator, counter and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            a_r       <= {EW{1'b0}};
            a3_r      <= {EW{1'b0}};
            p_r       <= {PW{1'b0}};
            k_r       <= {SELW{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= {(2*WIDTH){1'b0}};
`ifdef MUL_SIGNED_EN
            signed_r  <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            done_r  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        a_r    <= a_ext_s;
                        a3_r   <= a3_ext_s;
                        p_r    <= {PW{1'b0}};
                        k_r    <= {SELW{1'b0}};
                        busy_r <= 1'b1;
`ifdef MUL_SIGNED_EN
                        signed_r <= is_signed;
`endif
                    end
                end
                S_RUN: begin
                    p_r <= p_next_s;
                    if (k_r == LAST_K) begin
                        // The last step retires the product directly, so it is valid with done.
                        k_r       <= {SELW{1'b0}};
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        product_r <= p_next_s[2*WIDTH-1:0];
                    end else begin
                        k_r <= k_r + 5'd1;
                    end
                end
                S_DONE: begin
                    done_r <= 1'b0;
                end
                default: begin
                    k_r    <= {SELW{1'b0}};
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
